// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - six-digit multiplexed BCD seven-segment display driver
//
// Purpose:
//   Scans six BCD digits onto a common-anode seven-segment display, one digit
//   per slot of SCAN_DIV clocks. New values are staged in a shadow register
//   and only move into the display register at a slot boundary, so a digit
//   never changes in the middle of its slot.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (2 .. 2**20)
//
// Ports:
//   CLK     in   1   system clock, rising edge
//   RST_N   in   1   asynchronous active-low reset
//   LOAD    in   1   capture BCD_IN this cycle
//   BCD_IN  in  24   six BCD digits, digit k on [4k+3:4k]
//   LOADED  out  1   high in the boundary cycle that commits a new value
//   AN      out  6   active-low one-hot digit enables (registered)
//   SEG     out  7   active-low segments {g,f,e,d,c,b,a} (registered)
//
// Configuration:
//   LZB_EN  when defined, digits above the most significant nonzero digit are
//           blanked (digit 0 is always shown; A..F counts as nonzero).

module bcd_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [23:0] BCD_IN,
  output logic        LOADED,
  output logic [5:0]  AN,
  output logic [6:0]  SEG
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   disp_q, disp_d;
  logic [23:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          boundary;
  logic [3:0]    digit;
  logic [5:0]    zero_from;
  logic          blank;

  assign boundary = (cnt_q == CNT_LAST);

  // Combinational so that a LOAD on the boundary cycle reports in that cycle.
  assign LOADED = boundary & (LOAD | pend_q);

  always_comb begin
    cnt_d    = boundary ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (boundary) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      // A same-cycle LOAD is the newest value and wins over a pending one.
      if (LOAD) begin
        disp_d = BCD_IN;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = shadow_q;
        pend_d = 1'b0;
      end
    end else if (LOAD) begin
      shadow_d = BCD_IN;
      pend_d   = 1'b1;
    end
  end

  always_comb begin
    digit = 4'h0;
    case (idx_q)
      3'd0:    digit = disp_q[3:0];
      3'd1:    digit = disp_q[7:4];
      3'd2:    digit = disp_q[11:8];
      3'd3:    digit = disp_q[15:12];
      3'd4:    digit = disp_q[19:16];
      3'd5:    digit = disp_q[23:20];
      default: digit = 4'h0;
    endcase
  end

  // zero_from[k] is set when digit k and every digit above it are zero.
  always_comb begin
    zero_from[5] = (disp_q[23:20] == 4'h0);
    for (int k = 4; k >= 0; k--) begin
      zero_from[k] = (disp_q[4*k +: 4] == 4'h0) & zero_from[k+1];
    end
  end

`ifdef LZB_EN
  assign blank = (idx_q != 3'd0) && (idx_q <= 3'd5) && zero_from[idx_q];
`else
  assign blank = 1'b0;
  logic unused_zero;
  assign unused_zero = ^zero_from;
`endif

  always_comb begin
    seg_d = 7'h3F;
    case (digit)
      4'h0:    seg_d = 7'h40;
      4'h1:    seg_d = 7'h79;
      4'h2:    seg_d = 7'h24;
      4'h3:    seg_d = 7'h30;
      4'h4:    seg_d = 7'h19;
      4'h5:    seg_d = 7'h12;
      4'h6:    seg_d = 7'h02;
      4'h7:    seg_d = 7'h78;
      4'h8:    seg_d = 7'h00;
      4'h9:    seg_d = 7'h10;
      default: seg_d = 7'h3F;
    endcase
    an_d = ~(6'b000001 << idx_q);
    if (blank) begin
      seg_d = 7'h7F;
      an_d  = 6'h3F;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      disp_q   <= 24'h0;
      shadow_q <= 24'h0;
      pend_q   <= 1'b0;
      an_q     <= 6'h3F;
      seg_q    <= 7'h7F;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display (SCAN_DIV=4)
module tb_bcd_scan_display;

  localparam int SD = 4;
`ifdef LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LOAD;
  logic [23:0] BCD_IN;
  logic        LOADED;
  logic [5:0]  AN;
  logic [6:0]  SEG;

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .LOAD   (LOAD),
    .BCD_IN (BCD_IN),
    .LOADED (LOADED),
    .AN     (AN),
    .SEG    (SEG)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since reset release, committed display, staged value.
  int          m_t;
  logic [23:0] m_disp, m_shadow;
  bit          m_pend;
  int          n_loaded;
  logic        last_loaded;
  logic [6:0]  obs_seg [6];

  typedef struct packed {
    logic [23:0]      bcd;
    logic [5:0][6:0]  seg;
    logic [5:0]       blank_mask;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
      4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
      4'h9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void exp_out(input int idx, input logic [23:0] d,
                                  output logic [5:0] an, output logic [6:0] seg);
    logic [23:0] up;
    up = d >> (4 * idx);
    if (LZB && idx > 0 && up == 24'h0) begin
      an  = 6'h3F;
      seg = 7'h7F;
    end else begin
      an  = ~(6'd1 << idx);
      seg = dec7(up[3:0]);
    end
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_disp   = 24'h0;
    m_shadow = 24'h0;
    m_pend   = 0;
  endtask

  // One clock: drive inputs, check LOADED mid-cycle, check AN/SEG after the edge.
  task automatic step(input logic ld, input logic [23:0] bcd);
    bit         bnd;
    int         idx;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    LOAD   = ld;
    BCD_IN = bcd;
    bnd = (m_t % SD) == SD - 1;
    idx = (m_t / SD) % 6;
    exp_out(idx, m_disp, e_an, e_seg);
    #3;
    chk("loaded", {31'd0, LOADED}, {31'd0, bnd && (ld || m_pend)});
    last_loaded = LOADED;
    if (LOADED === 1'b1) n_loaded++;
    if (bnd) begin
      if (ld) m_disp = bcd;
      else if (m_pend) m_disp = m_shadow;
      if (ld || m_pend) m_pend = 0;
    end else if (ld) begin
      m_shadow = bcd;
      m_pend   = 1;
    end
    m_t++;
    @(posedge CLK);
    #1;
    chk("an", {26'd0, AN}, {26'd0, e_an});
    chk("seg", {25'd0, SEG}, {25'd0, e_seg});
    obs_seg[idx] = SEG;
  endtask

  task automatic align(input int phase);
    while ((m_t % SD) != phase) step(1'b0, 24'h0);
  endtask

  initial begin
    vecs[0] = '{24'h123456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'b000000};
    vecs[1] = '{24'h000900, {7'h40, 7'h40, 7'h40, 7'h10, 7'h40, 7'h40}, 6'b111000};
    vecs[2] = '{24'h00000A, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 6'b111110};
    vecs[3] = '{24'h222222, {7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24}, 6'b000000};
    vecs[4] = '{24'h0F0789, {7'h40, 7'h3F, 7'h40, 7'h78, 7'h00, 7'h10}, 6'b100000};

    RST_N  = 1'b0;
    LOAD   = 1'b0;
    BCD_IN = 24'h0;
    n_loaded = 0;
    last_loaded = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_an", {26'd0, AN}, 32'h3F);
    chk("rst_seg", {25'd0, SEG}, 32'h7F);
    chk("rst_loaded", {31'd0, LOADED}, 32'h0);

    RST_N = 1'b1;
    model_reset();
    step(1'b0, 24'h0);
    chk("first_an", {26'd0, AN}, 32'h3E);
    chk("first_seg", {25'd0, SEG}, 32'h40);
    repeat (27) step(1'b0, 24'h0);

    // Table: load mid-slot, scan all six digits, compare against constants.
    for (int v = 0; v < 5; v++) begin
      align(1);
      step(1'b1, vecs[v].bcd);
      repeat (32) step(1'b0, 24'h0);
      for (int k = 0; k < 6; k++) begin
        logic [6:0] e;
        e = (LZB && vecs[v].blank_mask[k]) ? 7'h7F : vecs[v].seg[k];
        chk($sformatf("table%0d_dig%0d", v, k), {25'd0, obs_seg[k]}, {25'd0, e});
      end
    end

    // LOAD on the boundary cycle commits immediately.
    align(SD - 1);
    step(1'b1, 24'h000900);
    chk("bnd_loaded", {31'd0, last_loaded}, 32'h1);

    // Two LOADs in one slot: one pulse, latest value shown.
    align(0);
    n_loaded = 0;
    step(1'b1, 24'h111111);
    step(1'b1, 24'h222222);
    repeat (30) step(1'b0, 24'h0);
    chk("one_pulse", n_loaded, 32'd1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("two_load_dig%0d", k), {25'd0, obs_seg[k]}, 32'h24);

    // Reset while pending: outputs forced asynchronously, value discarded.
    align(0);
    step(1'b1, 24'h123456);
    LOAD  = 1'b0;
    RST_N = 1'b0;
    #2;
    chk("async_an", {26'd0, AN}, 32'h3F);
    chk("async_seg", {25'd0, SEG}, 32'h7F);
    chk("async_loaded", {31'd0, LOADED}, 32'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
    n_loaded = 0;
    repeat (30) step(1'b0, 24'h0);
    chk("no_pulse_after_rst", n_loaded, 32'd0);
    chk("rst_disp_dig0", {25'd0, obs_seg[0]}, 32'h40);
    chk("rst_disp_dig5", {25'd0, obs_seg[5]}, LZB ? 32'h7F : 32'h40);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [23:0] r;
      r = 24'($urandom) >> (4 * $urandom_range(0, 6));
      step($urandom_range(0, 3) == 0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port LOAD  input  1  request to capture BCD_IN, sampled each CLK edge.
REQ-005 The block SHALL have port BCD_IN  input  24  six BCD digits, digit k on bits [4k+3:4k], digit 0 least significant (counter output).
REQ-006 The block SHALL have port LOADED  output  1  one-cycle pulse when a captured value enters the display register.
REQ-007 The block SHALL have port AN  output  6  digit enables, active-low, one-hot, AN[k] selects digit k.
REQ-008 The block SHALL have port SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 The block SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; the wrap cycle SHALL be the slot boundary.
REQ-010 The block SHALL advance digit index IDX 0->1->...->5->0 by one at each slot boundary.
REQ-011 On LOAD=1 the block SHALL copy BCD_IN into a shadow register and set PENDING.
REQ-012 At a slot boundary with PENDING set, the block SHALL move the shadow into the display register, clear PENDING, and assert LOADED for exactly that cycle.
REQ-013 If LOAD=1 on a boundary cycle, BCD_IN from that same cycle SHALL go directly to the display register, with LOADED=1 and PENDING left clear.
REQ-014 A second LOAD before the boundary SHALL overwrite the shadow; only the latest value SHALL be displayed, with one LOADED pulse.
REQ-015 The display register SHALL change only at slot boundaries, so a displayed digit never changes mid-slot.
REQ-016 SEG and AN SHALL be registered and SHALL reflect IDX and the display register with one cycle of latency.
REQ-017 Digit decode SHALL be: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h; values A..F SHALL show a dash, 3Fh.
REQ-018 A blanked digit SHALL drive SEG=7Fh and AN=6'b111111 for its slot.

Reset
REQ-019 RST_N=0 SHALL immediately force: prescaler=0, IDX=0, display=0, shadow=0, PENDING=0, LOADED=0, AN=6'b111111, SEG=7Fh.
REQ-020 The first CLK edge after reset release SHALL produce AN=6'b111110, SEG=40h.
REQ-021 Reset during PENDING SHALL discard the shadow with no LOADED pulse.

Configuration
REQ-022 Macro LZB_EN defined: digits above the most significant nonzero digit SHALL be blanked per REQ-018; digit 0 is never blanked; a dash digit counts as nonzero.
REQ-023 LZB_EN undefined: all six digits SHALL always be displayed, leading zeros included.

Verification (SCAN_DIV=4)
REQ-024 Reset release, no LOAD -> AN cycles 111110,111101,...,011111, each for 4 CLK; SEG=40h throughout (7Fh on digits 1..5 with LZB_EN).
REQ-025 LOAD one cycle with BCD_IN=123456h mid-slot -> LOADED at next boundary only; digit 0 shows 02h, digit 5 shows 79h.
REQ-026 LOAD on boundary cycle with 000900h -> LOADED same cycle; with LZB_EN digits 3..5 blanked, digit 2=10h, digits 0..1=40h.
REQ-027 Two LOADs in one slot (111111h then 222222h) -> one LOADED pulse; all digits show 24h.
REQ-028 BCD_IN=00000Ah loaded -> digit 0 shows 3Fh; with LZB_EN digits 1..5 blanked.
REQ-029 RST_N low for 1 cycle while PENDING -> outputs per REQ-019 asynchronously, no LOADED, display=0 after release.
